agc_sample_tx: RTL and testbench

//   Serial transmitter for the AGC output stream. Takes 8-bit gain-corrected samples on a

---
 rtl/agc_pkg.sv | 12 +
 rtl/agc_tx_fifo.sv | 75 +++++++
 rtl/agc_sample_tx.sv | 148 ++++++++++++++
 tb/tb_agc_sample_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC core, its serial sample transmitter and the TT wrapper.
package agc_pkg;

  localparam int AGC_SAMPLE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/agc_tx_fifo.sv
// Small synchronous FIFO buffering AGC samples ahead of the serial transmitter.
module agc_tx_fifo
  import agc_pkg::*;
#(
  parameter int WIDTH = AGC_SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Flags are decoded from the registered count, so ready never depends on valid.
  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == (AW+1)'(0));
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/agc_sample_tx.sv
// SPI mode-0 transmitter for the AGC output stream: FIFO-buffered samples are shifted
// out MSB-first on sclk/sdo framed by cs_n, with a gap of one bit-time between frames.
module agc_sample_tx
  import agc_pkg::*;
#(
  parameter int WIDTH   = AGC_SAMPLE_W,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             sclk,
  output logic             sdo,
  output logic             cs_n,
  output logic             busy,
  output logic             overflow
);

  localparam int DW = $clog2(2*CLK_DIV) + 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(2*CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             sclk_q, sclk_d, sdo_q, sdo_d, cs_n_q, cs_n_d;
  logic             busy_q, busy_d, ovf_q, ovf_d;
  logic             push_s, pop_s, full_s, empty_s;
  logic [WIDTH-1:0] fifo_data_s;

  assign push_s       = sample_valid && !full_s;
  assign sample_ready = !full_s;
  assign sclk         = sclk_q;
  assign sdo          = sdo_q;
  assign cs_n         = cs_n_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;

  agc_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i (sample_in),
    .pop_i   (pop_s),
    .rdata_o (fifo_data_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Frame sequencer: divider, bit counter, shift register and pin values.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    cs_n_d  = cs_n_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shreg_d = fifo_data_s;
          sdo_d   = fifo_data_s[WIDTH-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
          sdo_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q == HALF_END) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == LAST_BIT) begin
            // Last falling edge closes the frame instead of shifting.
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            sdo_d   = 1'b0;
            state_d = GAP;
          end else begin
            sclk_d  = 1'b0;
            shreg_d = shreg_q << 1;
            sdo_d   = shreg_q[WIDTH-2];
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      GAP: begin
        if (div_q == GAP_END) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d   = div_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        sdo_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE) || !empty_s || push_s;
    ovf_d  = ovf_q || (sample_valid && full_s);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_agc_sample_tx.sv
// Scoreboard bench for agc_sample_tx: a timing-level model predicts accepted samples and
// frame start cycles; monitors decode the serial pins and compare against the queue.
module tb_agc_sample_tx;
  localparam int W      = 8;
  localparam int D      = 4;
  localparam int CD     = 2;
  localparam int PERIOD = 2*CD*(W+1) + 1;
  localparam int BUSYW  = 2*CD*(W+1);

  typedef struct packed {
    logic [7:0]  d;
    int unsigned st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready, sclk, sdo, cs_n, busy, overflow;
  logic [7:0] sample_in2 = 8'h00;
  logic       sample_valid2 = 1'b0;
  logic       sample_ready2, sclk2, sdo2, cs_n2, busy2, overflow2;

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  int frames = 0;
  int frames2 = 0;

  logic [7:0]  mq[$];
  exp_t        sb[$];
  int unsigned next_free = 0;
  int unsigned last_pop = 0;
  bit          popped = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ovf = 1'b0;

  agc_sample_tx #(.WIDTH(W), .DEPTH(D), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sclk(sclk), .sdo(sdo), .cs_n(cs_n),
    .busy(busy), .overflow(overflow)
  );

  agc_sample_tx #(.WIDTH(W), .DEPTH(D), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in2), .sample_valid(sample_valid2),
    .sample_ready(sample_ready2), .sclk(sclk2), .sdo(sdo2), .cs_n(cs_n2),
    .busy(busy2), .overflow(overflow2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check flags, then advance the model across the coming edge.
  task automatic step(input logic v, input logic [7:0] d);
    int unsigned e;
    bit was_full;
    sample_valid = v;
    sample_in    = d;
    @(negedge clk);
    chk("sample_ready", sample_ready, mq.size() < D);
    chk("busy", busy, m_busy);
    chk("overflow", overflow, m_ovf);
    e = cyc + 1;
    was_full = (mq.size() >= D);
    if (mq.size() > 0 && e >= next_free) begin
      sb.push_back('{mq.pop_front(), e});
      next_free = e + PERIOD;
      last_pop  = e;
      popped    = 1'b1;
    end
    if (v) begin
      if (!was_full) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    m_busy = (mq.size() > 0) || (popped && e < last_pop + BUSYW);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    sb.delete();
    next_free = 0;
    popped = 1'b0;
    m_busy = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_ready", sample_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0 && mq.size() == 0 && !m_busy) break;
      step(1'b0, 8'h00);
    end
    chk("drain_timeout", sb.size() + mq.size() + m_busy, 0);
  endtask

  // Monitor for the CLK_DIV=2 instance: decode frames, check pin discipline.
  initial begin
    bit in_f = 1'b0, pv = 1'b0;
    logic p_sclk = 1'b0, p_sdo = 1'b0;
    logic [7:0] word = 8'h00;
    int len = 0, nb = 0;
    int unsigned st = 0;
    exp_t ex;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_f = 1'b0;
        pv   = 1'b0;
      end else begin
        if (pv && sclk) chk("sdo_stable_sclk_high", sdo, p_sdo);
        if (cs_n) chk("sclk_idle_low", sclk, 1'b0);
        if (!cs_n && !in_f) begin
          in_f = 1'b1; st = cyc; len = 0; nb = 0; word = 8'h00;
        end
        if (in_f) begin
          if (!cs_n) len++;
          if (sclk && !p_sclk) begin
            word = {word[6:0], sdo};
            nb++;
          end
          if (cs_n) begin
            in_f = 1'b0;
            frames++;
            chk("frame_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
              ex = sb.pop_front();
              chk("frame_data", word, ex.d);
              chk("frame_start", st, ex.st);
              chk("frame_cs_len", len, 2*CD*W);
              chk("frame_bits", nb, W);
            end
          end
        end
        p_sclk = sclk;
        p_sdo  = sdo;
        pv     = 1'b1;
      end
    end
  end

  // Monitor for the CLK_DIV=1 instance.
  initial begin
    bit in_f = 1'b0;
    logic p_sclk = 1'b0;
    logic [7:0] word = 8'h00;
    int len = 0, nb = 0;
    int unsigned last_rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_f = 1'b0;
        p_sclk = 1'b0;
      end else begin
        if (!cs_n2 && !in_f) begin
          in_f = 1'b1; len = 0; nb = 0; word = 8'h00;
        end
        if (in_f) begin
          if (!cs_n2) len++;
          if (sclk2 && !p_sclk) begin
            if (nb > 0) chk("div1_sclk_period", cyc - last_rise, 2);
            last_rise = cyc;
            word = {word[6:0], sdo2};
            nb++;
          end
          if (cs_n2) begin
            in_f = 1'b0;
            frames2++;
            chk("div1_data", word, 8'h5A);
            chk("div1_cs_len", len, 16);
            chk("div1_bits", nb, 8);
          end
        end
        p_sclk = sclk2;
      end
    end
  end

  initial begin
    int fr_before;
    do_reset();

    // Single frame, gap and busy fall.
    step(1'b1, 8'hA5);
    drain();

    // Four back-to-back samples.
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h3C);
    step(1'b1, 8'h81);
    drain();
    chk("t2_frames", frames, 5);

    // Overflow: six consecutive offers into a depth-4 FIFO.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h11 + i));
    drain();
    chk("t3_frames", frames, 10);
    chk("t3_overflow_sticky", overflow, 1'b1);

    // Reset in the middle of a frame with two samples queued.
    do_reset();
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    step(1'b1, 8'hC3);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00);
    fr_before = frames;
    do_reset();
    for (int i = 0; i < 90; i++) step(1'b0, 8'h00);
    chk("t4_no_frames", frames, fr_before);

    // CLK_DIV=1 instance.
    sample_valid2 = 1'b1;
    sample_in2 = 8'h5A;
    step(1'b0, 8'h00);
    sample_valid2 = 1'b0;
    for (int i = 0; i < 30; i++) step(1'b0, 8'h00);
    chk("t5_frames", frames2, 1);

    // Random traffic with random gaps.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, 8'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
